// File: rtl/uart_tx_param.sv
// uart_tx_param: bit-rate-clocked UART transmitter with input FIFO, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add a tx_break input that holds the idle line low.
module uart_tx_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                          uart_clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [DATA_WIDTH-1:0]         tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic                          tx_break,
`endif
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int MAXB  = DATA_WIDTH > STOP_BITS ? DATA_WIDTH : STOP_BITS;
    localparam int CW    = $clog2(MAXB);
    localparam bit PAR_EN  = PARITY_MODE == 1 || PARITY_MODE == 2;
    localparam bit PAR_ODD = PARITY_MODE == 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic [CW-1:0]         bit_cnt;
    logic                  brk;
    logic                  brk_q;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  last_stop;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break;
`else
    assign brk = 1'b0;
`endif

    assign tx_ready  = fifo_count < CNT_W'(FIFO_DEPTH);
    assign empty     = fifo_count == '0;
    assign push      = tx_valid && tx_ready;
    assign last_stop = state == STOP && bit_cnt == CW'(STOP_BITS - 1);
    // brk_q forces one high idle cycle after a break before the next start bit
    assign pop       = !empty && !brk && !brk_q && (state == IDLE || last_stop);

    always_ff @(posedge uart_clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
            brk_q   <= 1'b0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                state   <= START;
                shreg   <= mem[rd_ptr];
                par_bit <= ^mem[rd_ptr] ^ PAR_ODD;
                bit_cnt <= '0;
                tx_out  <= 1'b0;
                tx_busy <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx_out <= !brk;
                        brk_q  <= brk;
                    end
                    START: begin
                        state   <= DATA;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            state   <= PAR_EN ? PARITY : STOP;
                            tx_out  <= PAR_EN ? par_bit : 1'b1;
                            bit_cnt <= '0;
                            tx_done <= !PAR_EN && STOP_BITS == 1;
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        tx_out  <= 1'b1;
                        bit_cnt <= '0;
                        tx_done <= STOP_BITS == 1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            tx_out  <= !brk;
                            brk_q   <= brk;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_done <= bit_cnt == CW'(STOP_BITS - 2);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
